// File: rtl/hex_disp_mux.sv
// -----------------------------------------------------------------------------
// hex_disp_mux
//
// Time-multiplexed driver for a common-anode 4-digit seven-segment display.
// It sits downstream of the 4-digit hex sequence counter. A free-running refresh
// counter picks one digit slot at a time. All four digits are captured together
// once per full scan, so a single scan never mixes old and new count values.
// While the counter reports "paused", the whole display blinks.
//
// Ports:
//   clk        in   1  system clock, all state on rising edge
//   reset      in   1  asynchronous, active-high; clears all state
//   hex0..hex3 in   4  count digits, hex0 least significant
//   pause_clk  in   1  counter-paused flag; high enables blinking
//   an         out  4  anode enables, active-low; an[k] selects digit k
//   seg        out  7  segments, active-low, {g,f,e,d,c,b,a}
//   dp         out  1  decimal point, active-low; always off (1)
//
// Parameters:
//   REFRESH_BITS  width of the refresh counter; each slot lasts
//                 2^(REFRESH_BITS-2) cycles (minimum 3)
//   BLINK_BITS    width of the blink counter; blink period 2^BLINK_BITS
//                 cycles, 50% duty (minimum 2)
//
// Optional feature (compile-time macro LEADING_ZERO_BLANK_EN):
//   When defined, leading zero digits of the captured snapshot are blanked.
//   Digit 0 is never blanked. When undefined, every digit is shown.
// -----------------------------------------------------------------------------
module hex_disp_mux #(
  parameter int REFRESH_BITS = 18,
  parameter int BLINK_BITS   = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] hex0,
  input  logic [3:0] hex1,
  input  logic [3:0] hex2,
  input  logic [3:0] hex3,
  input  logic       pause_clk,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  generate
    if (REFRESH_BITS < 3) begin : g_bad_refresh
      $error("hex_disp_mux: REFRESH_BITS must be at least 3");
    end
    if (BLINK_BITS < 2) begin : g_bad_blink
      $error("hex_disp_mux: BLINK_BITS must be at least 2");
    end
  endgenerate

  localparam logic [REFRESH_BITS-1:0] Q_ONE = REFRESH_BITS'(1);
  localparam logic [BLINK_BITS-1:0]   B_ONE = BLINK_BITS'(1);

  // State registers and their next-state values
  logic [REFRESH_BITS-1:0] q_q,    q_d;
  logic [BLINK_BITS-1:0]   b_q,    b_d;
  logic [15:0]             snap_q, snap_d;
  logic [3:0]              an_q,   an_d;
  logic [6:0]              seg_q,  seg_d;

  // Combinational helpers
  logic [1:0] sel;
  logic [3:0] digit;
  logic [3:0] an_dec;
  logic [6:0] seg_dec;
  logic       lz_blank;
  logic       blink_blank;

  // Slot select comes from the top two bits of the refresh counter.
  assign sel = q_q[REFRESH_BITS-1 -: 2];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q    <= '0;
      b_q    <= '0;
      snap_q <= 16'h0000;
      an_q   <= 4'b1111;
      seg_q  <= 7'b1111111;
    end else begin
      q_q    <= q_d;
      b_q    <= b_d;
      snap_q <= snap_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Counters and snapshot
  // ---------------------------------------------------------------------------
  always_comb begin
    q_d = q_q + Q_ONE;

    // Capture on the last cycle of a scan, so the next scan (starting at
    // sel=0) shows one consistent set of digits.
    snap_d = snap_q;
    if (&q_q) begin
      snap_d = {hex3, hex2, hex1, hex0};
    end

    // The blink counter only runs while paused; releasing pause restarts the
    // blink phase from the visible half.
    if (pause_clk) begin
      b_d = b_q + B_ONE;
    end else begin
      b_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit select and decode
  // ---------------------------------------------------------------------------
  always_comb begin
    digit  = snap_q[3:0];
    an_dec = 4'b1110;
    case (sel)
      2'd0: begin digit = snap_q[3:0];   an_dec = 4'b1110; end
      2'd1: begin digit = snap_q[7:4];   an_dec = 4'b1101; end
      2'd2: begin digit = snap_q[11:8];  an_dec = 4'b1011; end
      2'd3: begin digit = snap_q[15:12]; an_dec = 4'b0111; end
      default: begin digit = snap_q[3:0]; an_dec = 4'b1110; end
    endcase
  end

  always_comb begin
    seg_dec = 7'b1111111;
    case (digit)
      4'h0: seg_dec = 7'b1000000;
      4'h1: seg_dec = 7'b1111001;
      4'h2: seg_dec = 7'b0100100;
      4'h3: seg_dec = 7'b0110000;
      4'h4: seg_dec = 7'b0011001;
      4'h5: seg_dec = 7'b0010010;
      4'h6: seg_dec = 7'b0000010;
      4'h7: seg_dec = 7'b1111000;
      4'h8: seg_dec = 7'b0000000;
      4'h9: seg_dec = 7'b0010000;
      4'hA: seg_dec = 7'b0001000;
      4'hB: seg_dec = 7'b0000011;
      4'hC: seg_dec = 7'b1000110;
      4'hD: seg_dec = 7'b0100001;
      4'hE: seg_dec = 7'b0000110;
      4'hF: seg_dec = 7'b0001110;
      default: seg_dec = 7'b1111111;
    endcase
  end

  // Leading-zero blanking looks at the snapshot, never at the live inputs.
`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    lz_blank = 1'b0;
    case (sel)
      2'd3: lz_blank = (snap_q[15:12] == 4'h0);
      2'd2: lz_blank = (snap_q[15:8]  == 8'h00);
      2'd1: lz_blank = (snap_q[15:4]  == 12'h000);
      default: lz_blank = 1'b0;
    endcase
  end
`else
  assign lz_blank = 1'b0;
`endif

  // Blank during the upper half of the blink period, only while paused, so
  // dropping pause restores the display on the very next edge.
  assign blink_blank = pause_clk & b_q[BLINK_BITS-1];

  // ---------------------------------------------------------------------------
  // Registered outputs (one cycle behind sel/snapshot)
  // ---------------------------------------------------------------------------
  always_comb begin
    an_d  = an_dec;
    seg_d = seg_dec;
    if (blink_blank || lz_blank) begin
      an_d  = 4'b1111;
      seg_d = 7'b1111111;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_hex_disp_mux.sv
// -----------------------------------------------------------------------------
// tb_hex_disp_mux
//
// Directed bench for hex_disp_mux with REFRESH_BITS=4 (4 cycles per slot,
// 16-cycle scan) and BLINK_BITS=6 (64-cycle blink period). Outputs are sampled
// 1 time unit after each rising edge. n_edge counts edges since the last reset
// release, so the slot shown after edge n is ((n-1) % 16) / 4.
// -----------------------------------------------------------------------------
module tb_hex_disp_mux;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] hex0, hex1, hex2, hex3;
  logic       pause_clk;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_vec  = 0;
  int n_err  = 0;
  int n_edge = 0;

  // Segment codes expected for the snapshot currently on display, per slot
  logic [6:0] cur_seg [4];
  logic [3:0] lz_mask;

  // Hand-derived segment codes
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SF = 7'b0001110;
  localparam logic [6:0] SB = 7'b1111111;  // blank

  always #5 clk = ~clk;

  hex_disp_mux #(
    .REFRESH_BITS(4),
    .BLINK_BITS  (6)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .hex0     (hex0),
    .hex1     (hex1),
    .hex2     (hex2),
    .hex3     (hex3),
    .pause_clk(pause_clk),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  // ---------------------------------------------------------------------------
  // Checking and driver tasks
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (edge %0d, t=%0t)", tag, got, exp, n_edge, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n_edge++;
  endtask

  function automatic logic [3:0] an_of(input int slot);
    case (slot)
      0: an_of = 4'b1110;
      1: an_of = 4'b1101;
      2: an_of = 4'b1011;
      default: an_of = 4'b0111;
    endcase
  endfunction

  task automatic set_hex(input logic [3:0] h3, input logic [3:0] h2,
                         input logic [3:0] h1, input logic [3:0] h0);
    hex3 = h3; hex2 = h2; hex1 = h1; hex0 = h0;
  endtask

  // One full scan starting at slot 0; mask bit k expects slot k blanked.
  task automatic scan_check(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] mask);
    logic [6:0] segs [4];
    int slot;
    segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
    for (int i = 0; i < 16; i++) begin
      step();
      slot = i / 4;
      if (mask[slot]) begin
        check({tag, "_an"},  {12'h000, an}, 16'h000F);
        check({tag, "_seg"}, {9'h000, seg}, {9'h000, SB});
      end else begin
        check({tag, "_an"},  {12'h000, an}, {12'h000, an_of(slot)});
        check({tag, "_seg"}, {9'h000, seg}, {9'h000, segs[slot]});
      end
    end
    check({tag, "_dp"}, {15'h0000, dp}, 16'h0001);
  endtask

  // Hold pause high for 'count' edges, checking the blink pattern, then drop
  // it at a point where the blink counter is in its blank half and confirm
  // the display returns on the next edge.
  task automatic blink_run(input string tag, input int count);
    int slot;
    pause_clk = 1'b1;
    for (int m = 1; m <= count; m++) begin
      step();
      slot = ((n_edge - 1) % 16) / 4;
      if (((m - 1) % 64) >= 32) begin
        check({tag, "_an_blank"},  {12'h000, an}, 16'h000F);
        check({tag, "_seg_blank"}, {9'h000, seg}, {9'h000, SB});
      end else begin
        check({tag, "_an_on"},  {12'h000, an}, {12'h000, an_of(slot)});
        check({tag, "_seg_on"}, {9'h000, seg}, {9'h000, cur_seg[slot]});
      end
    end
    pause_clk = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      slot = ((n_edge - 1) % 16) / 4;
      check({tag, "_resume_an"},  {12'h000, an}, {12'h000, an_of(slot)});
      check({tag, "_resume_seg"}, {9'h000, seg}, {9'h000, cur_seg[slot]});
    end
  endtask

  task automatic align_scan();
    while ((n_edge % 16) != 0) step();
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected summary");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
`ifdef LEADING_ZERO_BLANK_EN
    lz_mask = 4'b1100;
`else
    lz_mask = 4'b0000;
`endif
    reset     = 1'b1;
    pause_clk = 1'b0;
    set_hex(4'hA, 4'h5, 4'h0, 4'hF);

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_an",   {12'h000, an}, 16'h000F);
    check("rst_seg",  {9'h000, seg}, {9'h000, SB});
    check("rst_dp",   {15'h0000, dp}, 16'h0001);
    check("rst_snap", dut.snap_q, 16'h0000);
    reset  = 1'b0;
    n_edge = 0;

    // First scan shows the zero snapshot; second shows A,5,0,F.
    scan_check("scan1_zero", S0, S0, S0, S0, 4'b0000);
    scan_check("scan2_a50f", SF, S0, S5, SA, 4'b0000);

    // Reset mid-scan (slot 1): outputs blank before any edge.
    for (int i = 0; i < 6; i++) step();
    #3;
    reset = 1'b1;
    #1;
    check("midrst_an",  {12'h000, an}, 16'h000F);
    check("midrst_seg", {9'h000, seg}, {9'h000, SB});
    check("midrst_dp",  {15'h0000, dp}, 16'h0001);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("inrst_an",  {12'h000, an}, 16'h000F);
      check("inrst_seg", {9'h000, seg}, {9'h000, SB});
    end
    reset  = 1'b0;
    n_edge = 0;
    // First edge after release: digit 0 of the zero snapshot.
    scan_check("post_rst", S0, S0, S0, S0, 4'b0000);

    // Change hex0 F->3 while sel=2; this scan keeps showing A,5,0,F.
    for (int i = 0; i < 16; i++) begin
      step();
      case (i / 4)
        0: begin
          check("chg_an0",  {12'h000, an}, 16'h000E);
          check("chg_seg0", {9'h000, seg}, {9'h000, SF});
        end
        1: begin
          check("chg_an1",  {12'h000, an}, 16'h000D);
          check("chg_seg1", {9'h000, seg}, {9'h000, S0});
        end
        2: begin
          check("chg_an2",  {12'h000, an}, 16'h000B);
          check("chg_seg2", {9'h000, seg}, {9'h000, S5});
        end
        default: begin
          check("chg_an3",  {12'h000, an}, 16'h0007);
          check("chg_seg3", {9'h000, seg}, {9'h000, SA});
        end
      endcase
      if (i == 8) hex0 = 4'h3;
    end
    scan_check("after_chg", S3, S0, S5, SA, 4'b0000);

    // Blink while paused; digits A,5,0,3 on display underneath.
    cur_seg[0] = S3; cur_seg[1] = S0; cur_seg[2] = S5; cur_seg[3] = SA;
    blink_run("blink_long", 232);
    // Re-pause: the blink phase must have restarted from zero.
    blink_run("blink_again", 40);

    // Leading zeros: 0,0,7,0
    align_scan();
    set_hex(4'h0, 4'h0, 4'h7, 4'h0);
    for (int i = 0; i < 16; i++) step();
    scan_check("lz_scan1", S0, S7, S0, S0, lz_mask);
    scan_check("lz_scan2", S0, S7, S0, S0, lz_mask);
    scan_check("lz_scan3", S0, S7, S0, S0, lz_mask);

    // Snapshot loads only on the last edge of a scan, despite mid-scan input changes.
    set_hex(4'h9, 4'h9, 4'h9, 4'h9);
    for (int i = 0; i < 16; i++) begin
      step();
      check("snap_probe", dut.snap_q, (i == 15) ? 16'h1234 : 16'h0070);
      if (i == 5) set_hex(4'h1, 4'h2, 4'h3, 4'h4);
    end
    scan_check("scan_1234", S4, S3, S2, S1, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
